// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the multi-master asynchronous SRAM controller:
// FSM encoding, default build constants and the wait-counter width helper.
package sram_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t StIdle   = 2'd0;
    localparam state_t StSetup  = 2'd1;
    localparam state_t StAccess = 2'd2;
    localparam state_t StDone   = 2'd3;

    localparam int unsigned DefNumMasters = 2;
    localparam int unsigned DefAddrWidth  = 20;
    localparam int unsigned DefDataWidth  = 32;
    localparam int unsigned DefWaitCycles = 1;
    localparam int unsigned DefAddrLsb    = 2;

    // The ACCESS down-counter runs from wait_cycles-1 to 0.
    function automatic int unsigned wait_cnt_width(input int unsigned wait_cycles);
        return (wait_cycles > 1) ? $clog2(wait_cycles) : 1;
    endfunction

endpackage

// File: rtl/sram_multiport_ctrl_if.sv
// Master-side request/response bundle of the multi-master SRAM controller.
// All per-master fields are flattened, master m occupying slice m.
interface sram_multiport_ctrl_if
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DefNumMasters,
    parameter int unsigned DATA_WIDTH  = DefDataWidth
);
    localparam int unsigned SelW = DATA_WIDTH / 8;

    logic [NUM_MASTERS-1:0]            m_ce_i;
    logic [NUM_MASTERS-1:0]            m_we_i;
    logic [NUM_MASTERS*32-1:0]         m_addr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_i;
    logic [NUM_MASTERS*SelW-1:0]       m_sel_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] m_data_o;
    logic [NUM_MASTERS-1:0]            m_ack_o;
    logic [NUM_MASTERS-1:0]            grant_o;

    modport master (
        output m_ce_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
        input  m_data_o, m_ack_o, grant_o
    );

    modport slave (
        input  m_ce_i, m_we_i, m_addr_i, m_data_i, m_sel_i,
        output m_data_o, m_ack_o, grant_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i
// (wrapping) wins, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned cand;
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr_i) + k) % N;
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/sram_multiport_ctrl.sv
// Shares one asynchronous SRAM bank among NUM_MASTERS ports using round-robin
// arbitration and a fixed SETUP/ACCESS/DONE cycle with registered SRAM strobes.
module sram_multiport_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = DefNumMasters,
    parameter int unsigned ADDR_WIDTH  = DefAddrWidth,
    parameter int unsigned DATA_WIDTH  = DefDataWidth,
    parameter int unsigned WAIT_CYCLES = DefWaitCycles,
    parameter int unsigned ADDR_LSB    = DefAddrLsb
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_multiport_ctrl_if.slave    bus,
    inout  wire  [DATA_WIDTH-1:0]   ram_data,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH/8-1:0] ram_be_n,
    output logic                    ram_ce_n,
    output logic                    ram_oe_n,
    output logic                    ram_we_n
);

    localparam int unsigned SelW = DATA_WIDTH / 8;
    localparam int unsigned IdxW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned CntW = wait_cnt_width(WAIT_CYCLES);

    state_t                          state_q, state_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [IdxW-1:0]                 ptr_q, idx_q;
    logic [NUM_MASTERS-1:0]          gnt_q, ack_q;
    logic                            we_q;
    logic [DATA_WIDTH-1:0]           wdata_q;
    logic                            data_oe_q;
    logic [NUM_MASTERS*DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0]           ram_addr_q;
    logic [SelW-1:0]                 ram_be_n_q;
    logic                            ram_ce_n_q, ram_oe_n_q, ram_we_n_q;

    logic [NUM_MASTERS-1:0]          arb_gnt;
    logic [IdxW-1:0]                 arb_idx;
    logic                            arb_valid;

    logic                            new_we;
    logic [ADDR_WIDTH-1:0]           new_addr;
    logic [DATA_WIDTH-1:0]           new_data;
    logic [SelW-1:0]                 new_sel;
    logic                            cur_we;

    rr_arbiter #(
        .N (NUM_MASTERS)
    ) u_arb (
        .req_i   (bus.m_ce_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Request fields of whichever master the arbiter picks this cycle.
    always_comb begin
        new_we   = bus.m_we_i[arb_idx];
        new_addr = bus.m_addr_i[32*arb_idx + ADDR_LSB +: ADDR_WIDTH];
        new_data = bus.m_data_i[DATA_WIDTH*arb_idx +: DATA_WIDTH];
        new_sel  = bus.m_sel_i[SelW*arb_idx +: SelW];
        cur_we   = (state_q == StIdle) ? new_we : we_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (arb_valid) state_d = StSetup;
            end
            StSetup: begin
                state_d = StAccess;
                cnt_d   = CntW'(WAIT_CYCLES - 1);
            end
            StAccess: begin
                if (cnt_q == '0) state_d = StDone;
                else             cnt_d   = cnt_q - 1'b1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Strobes are computed from the next state so every SRAM pin is a flop output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ptr_q      <= '0;
            idx_q      <= '0;
            gnt_q      <= '0;
            ack_q      <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            data_oe_q  <= 1'b0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            ram_be_n_q <= '1;
            ram_ce_n_q <= 1'b1;
            ram_oe_n_q <= 1'b1;
            ram_we_n_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ram_ce_n_q <= (state_d == StIdle);
            ram_oe_n_q <= ~(~cur_we & ((state_d == StSetup) | (state_d == StAccess)));
            ram_we_n_q <= ~(cur_we & (state_d == StAccess));
            data_oe_q  <= cur_we & (state_d != StIdle);
            ack_q      <= (state_d == StDone) ? gnt_q : '0;
            if (state_q == StIdle && arb_valid) begin
                gnt_q      <= arb_gnt;
                idx_q      <= arb_idx;
                we_q       <= new_we;
                wdata_q    <= new_data;
                ram_addr_q <= new_addr;
                ram_be_n_q <= ~new_sel;
            end else if (state_d == StIdle) begin
                gnt_q      <= '0;
                ram_be_n_q <= '1;
            end
            if (state_q == StAccess && state_d == StDone && !we_q) begin
                rdata_q[DATA_WIDTH*idx_q +: DATA_WIDTH] <= ram_data;
            end
            if (state_q == StDone) begin
                ptr_q <= (idx_q == IdxW'(NUM_MASTERS - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

    assign ram_data     = data_oe_q ? wdata_q : {DATA_WIDTH{1'bz}};
    assign ram_addr     = ram_addr_q;
    assign ram_be_n     = ram_be_n_q;
    assign ram_ce_n     = ram_ce_n_q;
    assign ram_oe_n     = ram_oe_n_q;
    assign ram_we_n     = ram_we_n_q;
    assign bus.m_data_o = rdata_q;
    assign bus.m_ack_o  = ack_q;
    assign bus.grant_o  = gnt_q;

endmodule

// File: doc/sram_multiport_ctrl.md
Name: sram_multiport_ctrl

Overview:
Parametrised successor to the single-master RAM wrappers on the Thinpad top level. It lets NUM_MASTERS CPU-side ports (e.g. instruction fetch, data, DMA/flash loader) share one asynchronous SRAM bank (BaseRAM or ExtRAM) through round-robin arbitration. Each access runs through a fixed setup/access/done sequence with a configurable number of wait states. The block drives the SRAM strobes and tri-state data bus directly and returns a per-master ack.

Parameters:
NUM_MASTERS, 2, number of requesting ports (1..8)
ADDR_WIDTH, 20, SRAM word-address width
DATA_WIDTH, 32, SRAM data width (multiple of 8)
WAIT_CYCLES, 1, cycles in ACCESS state (>=1)
ADDR_LSB, 2, master byte-address bit mapped to SRAM addr[0]

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
m_ce_i  in  NUM_MASTERS  per-master request, held until ack
m_we_i  in  NUM_MASTERS  1=write, 0=read
m_addr_i  in  NUM_MASTERS*32  flattened byte addresses; SRAM addr = m_addr[ADDR_LSB +: ADDR_WIDTH]
m_data_i  in  NUM_MASTERS*DATA_WIDTH  flattened write data
m_sel_i  in  NUM_MASTERS*(DATA_WIDTH/8)  flattened byte enables, active high
m_data_o  out  NUM_MASTERS*DATA_WIDTH  flattened read data, lane held until next read by that master
m_ack_o  out  NUM_MASTERS  one-cycle completion pulse
grant_o  out  NUM_MASTERS  one-hot owner of current transaction (0 in IDLE)
ram_data  inout  DATA_WIDTH  SRAM data bus
ram_addr  out  ADDR_WIDTH  SRAM address
ram_be_n  out  DATA_WIDTH/8  byte enables, active low
ram_ce_n  out  1  chip select, active low
ram_oe_n  out  1  output enable, active low
ram_we_n  out  1  write enable, active low

Behaviour:
- Reset: state IDLE; ram_ce_n/oe_n/we_n = 1, ram_be_n all 1, ram_addr 0, ram_data high-Z; m_ack_o 0, grant_o 0, m_data_o 0; RR pointer = 0.
- FSM IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles, down-counter) -> DONE -> IDLE.
- IDLE: if any m_ce_i high, pick first requester at or after RR pointer (wrapping); latch its we, addr, data, sel; grant_o set; go SETUP. Else stay.
- SETUP: ram_addr, ram_be_n = ~sel, ram_ce_n = 0 driven. Read: ram_oe_n = 0. Write: ram_data driven, ram_we_n stays 1.
- ACCESS: read holds oe_n = 0; write asserts we_n = 0 for all WAIT_CYCLES cycles with data driven. On the last ACCESS edge, a read samples ram_data into the granted master's m_data_o lane.
- DONE: we_n = 1, oe_n = 1, ce_n = 0. Write data stays driven this cycle (hold time). m_ack_o[granted] = 1 for exactly this cycle. RR pointer = (granted+1) mod NUM_MASTERS.
- Latency: request seen in IDLE at cycle 0 -> ack at cycle WAIT_CYCLES+2. One transaction per WAIT_CYCLES+3 cycles under back-to-back load.
- Masters drop m_ce_i or change the request in the cycle after ack. A ce still high in IDLE starts a new transaction.
- Request inputs are sampled only in IDLE. Changes mid-transaction have no effect; a master that drops ce mid-transaction still gets its ack.
- sel = 0: full sequence still runs with be_n all 1; ack still returned.
- Simultaneous requests: strict RR, so no master waits more than NUM_MASTERS-1 transactions.
- Reset mid-transaction: abort to IDLE next edge, strobes deasserted, bus released, no ack, pointer reset.
- ram_data is driven only during SETUP/ACCESS/DONE of a write; otherwise high-Z.
- All SRAM outputs are registered (no combinational paths from m_* to ram_*).

Decomposition:
- Package sram_ctrl_pkg: state encoding (IDLE, SETUP, ACCESS, DONE), width helper for the wait counter, default parameter constants.
- Sub-module rr_arbiter (parameter N): req vector + pointer -> one-hot grant and index, combinational. Reused by future bus interconnect.

Test Plan:
- Single read, NUM_MASTERS=2, WAIT_CYCLES=1: m0 read addr 0x0000_0010, SRAM model holds 0xDEADBEEF at word 4 -> ram_addr=4, oe_n low for 2 cycles, ack[0] at cycle 3, m_data_o lane0=0xDEADBEEF.
- Byte write: m1 write addr 0x8, data 0x11223344, sel 4'b0100 -> ram_be_n=4'b1011, we_n low exactly 1 cycle, model word 2 byte2=0x22 only, ack[1] at cycle 3.
- Contention: m0 and m1 both request continuously from reset -> grants alternate 0,1,0,1; acks spaced 4 cycles apart; no starvation over 20 transactions.
- WAIT_CYCLES=3 build: read -> oe_n low 4 cycles, ack at cycle 5; write -> we_n low exactly 3 cycles; data driven one cycle after we_n rises.
- Reset asserted during ACCESS of a write -> next cycle all strobes 1, ram_data high-Z, no ack; first request after reset is granted to m0.
- sel=0 write, then read same word -> memory unchanged, both acks returned with normal latency.
